axi2mem_tcdm_arbiter: RTL and testbench
=======================================

# axi2mem_tcdm_arbiter

Shares one 32-bit TCDM initiator port between the axi2mem read channel and write channel. Each cycle it selects one requester, with round-robin fairness and a lock that holds the selection while a request waits for grant. It records the owner of every granted request in an in-order owner queue. It routes each TCDM response (r_valid/r_rdata) back to the channel that issued it.

## Interface
- OUTSTANDING, default 4: maximum granted-but-unanswered TCDM requests. Minimum 2, power of two.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- test_en_i  in  1  test mode, forwarded to the owner queue.
- rd_req_i  in  1  read-channel request.
- rd_add_i  in  32  read-channel address.
- rd_we_i  in  1  read-channel access type; 1 = read, 0 = write (TCDM convention).
- rd_wdata_i  in  32  read-channel write data.
- rd_be_i  in  4  read-channel byte enables.
- rd_gnt_o  out  1  read-channel grant.
- rd_r_rdata_o  out  32  read-channel response data.
- rd_r_valid_o  out  1  read-channel response valid.
- wr_req_i, wr_add_i, wr_we_i, wr_wdata_i, wr_be_i, wr_gnt_o, wr_r_rdata_o, wr_r_valid_o: write-channel set, same directions, widths and meanings.
- tcdm_req_o  out  1  TCDM request.
- tcdm_add_o  out  32  TCDM address.
- tcdm_we_o  out  1  TCDM access type.
- tcdm_wdata_o  out  32  TCDM write data.
- tcdm_be_o  out  4  TCDM byte enables.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_r_rdata_i  in  32  TCDM response data.
- tcdm_r_valid_i  in  1  TCDM response valid.
- idle_o  out  1  no request pending and owner queue empty.
- err_o  out  1  sticky: response received with an empty owner queue.

## Operation
- Eligibility: a channel is eligible when its req is high and the owner queue is not full. A full queue masks both channels, even if a pop happens in the same cycle.
- Selection:
  - If lock is set, the locked owner is selected.
  - Otherwise, if exactly one channel is eligible, that channel is selected.
  - Otherwise, if both are eligible, the channel indicated by rr_ptr is selected.
- rr_ptr register (0 = rd, 1 = wr):
  - After a granted transfer it points to the channel that was not served.
  - Reset value 0, so rd wins the first tie.
- Lock register:
  - Set when the selected channel's req is high and tcdm_gnt_i = 0; stores the owner.
  - Cleared on grant, or when the locked channel drops req (the TCDM protocol allows withdrawal).
  - While lock is set, the other channel is never selected.
- Muxing: tcdm_add/we/wdata/be come from the selected channel. tcdm_req_o = selected req. When nothing is selected, all are 0.
- Grant: sel_gnt_o = tcdm_gnt_i & tcdm_req_o, sent to the selected channel only. The unselected channel's gnt is 0.
- Owner queue: on each grant, push the owner bit. On tcdm_r_valid_i, pop the head and drive <head>_r_valid_o = 1.
- Response data: tcdm_r_rdata_i is wired to both rd_r_rdata_o and wr_r_rdata_o unconditionally.
- Writes also return r_valid, and that response is routed to the write's owner the same way.
- Response on empty queue: set err_o and assert neither r_valid. The queue state is unchanged.
- Outputs in reset: all gnt, r_valid and tcdm_req_o = 0; idle_o = 1; err_o = 0. Data outputs follow the mux and are don't-care.

## Timing
- Request path is combinational: req/add -> tcdm_*, and tcdm_gnt_i -> *_gnt_o, both with 0-cycle latency.
- Response routing is combinational from the registered queue head. tcdm_r_valid_i -> *_r_valid_o has 0-cycle latency.
- Push and pop in the same cycle: count is unchanged and both operations take effect.
- TCDM may return r_valid as early as the cycle after grant. Responses arrive strictly in grant order.
- Sustained throughput is one request per cycle provided responses keep up. Under contention the two channels alternate grants every cycle.
- Asynchronous reset mid-operation clears rr_ptr, lock, queue pointers and err_o. Responses still in flight after reset are flagged by err_o.

## Structure
- Shared package axi2mem_pkg defines:
  - typedef tcdm_owner_e: OWNER_RD = 1'b0, OWNER_WR = 1'b1.
  - localparam TCDM_DW = 32, TCDM_BEW = 4.
- Sub-module axi2mem_owner_fifo: 1-bit wide, OUTSTANDING deep, with full, empty and a count of width $clog2(OUTSTANDING)+1.
- Top-level: arbitration and lock logic plus the muxes.

## Test plan
- Reset: rst_ni low with both req high -> tcdm_req_o = 0, gnts = 0, idle_o = 1. After release, with gnt high, rd is granted first at address 0x1000_0000.
- Contention: both channels request continuously with gnt = 1 and r_valid one cycle later -> grants alternate rd, wr, rd, wr. Each r_valid returns only to the issuer, and rd_r_rdata_o = 0xDEAD_BEEF when that value is returned.
- Lock: wr selected with gnt = 0 for 3 cycles while rd requests -> tcdm_add_o stays at wr's address. Then gnt = 1 -> wr_gnt_o = 1, and rd is granted next cycle.
- Full queue: OUTSTANDING = 4 with no responses -> after 4 grants, tcdm_req_o = 0. Then a single r_valid -> head is popped, and the next cycle grants again.
- Withdrawal: rd locked with gnt = 0, then rd_req_i drops -> lock clears and wr is granted in the same cycle if it is requesting.
- Spurious response: tcdm_r_valid_i with an empty queue -> err_o = 1 and stays 1, no r_valid is asserted, idle_o remains 1.

Source files
------------

// File: rtl/axi2mem_pkg.sv
// Shared types and widths for the axi2mem TCDM path.
package axi2mem_pkg;

   typedef enum logic {
      OWNER_RD = 1'b0,
      OWNER_WR = 1'b1
   } tcdm_owner_e;

   localparam int TCDM_DW  = 32;
   localparam int TCDM_BEW = 4;

endpackage

// File: rtl/axi2mem_owner_fifo.sv
// In-order queue of request owners; the head names the channel that gets
// the next TCDM response.
module axi2mem_owner_fifo
   import axi2mem_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          test_en,
   input  logic          push,
   input  tcdm_owner_e   push_data,
   input  logic          pop,
   output tcdm_owner_e   head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   tcdm_owner_e   mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          push_ok;
   logic          pop_ok;
   logic          unused_test_en;

   // No clock gating in this queue, so test mode has nothing to bypass.
   assign unused_test_en = test_en;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_reg[gi] <= OWNER_RD;
         end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
            mem_reg[gi] <= push_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

endmodule

// File: rtl/axi2mem_tcdm_arbiter.sv
// Round-robin arbiter with grant lock sharing one TCDM port between the
// axi2mem read and write channels; responses return via an owner queue.
module axi2mem_tcdm_arbiter
   import axi2mem_pkg::*;
#(
   parameter int OUTSTANDING = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                test_en_i,

   input  logic                rd_req_i,
   input  logic [TCDM_DW-1:0]  rd_add_i,
   input  logic                rd_we_i,
   input  logic [TCDM_DW-1:0]  rd_wdata_i,
   input  logic [TCDM_BEW-1:0] rd_be_i,
   output logic                rd_gnt_o,
   output logic [TCDM_DW-1:0]  rd_r_rdata_o,
   output logic                rd_r_valid_o,

   input  logic                wr_req_i,
   input  logic [TCDM_DW-1:0]  wr_add_i,
   input  logic                wr_we_i,
   input  logic [TCDM_DW-1:0]  wr_wdata_i,
   input  logic [TCDM_BEW-1:0] wr_be_i,
   output logic                wr_gnt_o,
   output logic [TCDM_DW-1:0]  wr_r_rdata_o,
   output logic                wr_r_valid_o,

   output logic                tcdm_req_o,
   output logic [TCDM_DW-1:0]  tcdm_add_o,
   output logic                tcdm_we_o,
   output logic [TCDM_DW-1:0]  tcdm_wdata_o,
   output logic [TCDM_BEW-1:0] tcdm_be_o,
   input  logic                tcdm_gnt_i,
   input  logic [TCDM_DW-1:0]  tcdm_r_rdata_i,
   input  logic                tcdm_r_valid_i,

   output logic                idle_o,
   output logic                err_o
);

   localparam int CW = $clog2(OUTSTANDING) + 1;

   logic          fifo_full;
   logic          fifo_empty;
   tcdm_owner_e   fifo_head;
   logic [CW-1:0] unused_fifo_count;

   logic          rd_elig, wr_elig;
   logic          lock_hold;
   logic          sel_valid;
   tcdm_owner_e   sel_owner;
   logic          grant;
   logic          resp_ok;

   logic          lock_reg, lock_next;
   tcdm_owner_e   lock_owner_reg, lock_owner_next;
   tcdm_owner_e   rr_reg, rr_next;
   logic          err_reg, err_next;

   // Selection; rst_ni gating keeps the request side quiet while in reset.
   always_comb begin
      rd_elig   = rd_req_i & ~fifo_full & rst_ni;
      wr_elig   = wr_req_i & ~fifo_full & rst_ni;
      // A locked channel that withdrew its req no longer holds the port.
      lock_hold = lock_reg & ((lock_owner_reg == OWNER_WR) ? wr_elig : rd_elig);
      sel_valid = 1'b0;
      sel_owner = OWNER_RD;
      if (lock_hold) begin
         sel_valid = 1'b1;
         sel_owner = lock_owner_reg;
      end else if (rd_elig && wr_elig) begin
         sel_valid = 1'b1;
         sel_owner = rr_reg;
      end else if (rd_elig) begin
         sel_valid = 1'b1;
         sel_owner = OWNER_RD;
      end else if (wr_elig) begin
         sel_valid = 1'b1;
         sel_owner = OWNER_WR;
      end
   end

   always_comb begin
      tcdm_req_o   = sel_valid;
      tcdm_add_o   = '0;
      tcdm_we_o    = 1'b0;
      tcdm_wdata_o = '0;
      tcdm_be_o    = '0;
      if (sel_valid) begin
         if (sel_owner == OWNER_WR) begin
            tcdm_add_o   = wr_add_i;
            tcdm_we_o    = wr_we_i;
            tcdm_wdata_o = wr_wdata_i;
            tcdm_be_o    = wr_be_i;
         end else begin
            tcdm_add_o   = rd_add_i;
            tcdm_we_o    = rd_we_i;
            tcdm_wdata_o = rd_wdata_i;
            tcdm_be_o    = rd_be_i;
         end
      end
   end

   assign grant    = tcdm_gnt_i & sel_valid;
   assign rd_gnt_o = grant & (sel_owner == OWNER_RD);
   assign wr_gnt_o = grant & (sel_owner == OWNER_WR);

   assign resp_ok      = tcdm_r_valid_i & ~fifo_empty;
   assign rd_r_valid_o = resp_ok & (fifo_head == OWNER_RD);
   assign wr_r_valid_o = resp_ok & (fifo_head == OWNER_WR);
   assign rd_r_rdata_o = tcdm_r_rdata_i;
   assign wr_r_rdata_o = tcdm_r_rdata_i;

   assign idle_o = fifo_empty & ~sel_valid;
   assign err_o  = err_reg;

   always_comb begin
      lock_next       = sel_valid & ~tcdm_gnt_i;
      lock_owner_next = sel_valid ? sel_owner : lock_owner_reg;
      rr_next         = rr_reg;
      if (grant) begin
         rr_next = (sel_owner == OWNER_RD) ? OWNER_WR : OWNER_RD;
      end
      err_next = err_reg | (tcdm_r_valid_i & fifo_empty);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_reg       <= 1'b0;
         lock_owner_reg <= OWNER_RD;
         rr_reg         <= OWNER_RD;
         err_reg        <= 1'b0;
      end else begin
         lock_reg       <= lock_next;
         lock_owner_reg <= lock_owner_next;
         rr_reg         <= rr_next;
         err_reg        <= err_next;
      end
   end

   axi2mem_owner_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_owner_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .test_en   (test_en_i),
      .push      (grant),
      .push_data (sel_owner),
      .pop       (resp_ok),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_fifo_count)
   );

endmodule

// File: tb/tb_axi2mem_tcdm_arbiter.sv
// Directed vector bench for the axi2mem TCDM arbiter.
module tb_axi2mem_tcdm_arbiter;

   localparam logic [31:0] RD_ADD   = 32'h1000_0000;
   localparam logic [31:0] WR_ADD   = 32'h2000_0000;
   localparam logic [31:0] RD_WDATA = 32'hAAAA_0001;
   localparam logic [31:0] WR_WDATA = 32'hBBBB_0002;
   localparam logic [3:0]  RD_BE    = 4'hF;
   localparam logic [3:0]  WR_BE    = 4'h3;

   typedef struct {
      logic        rd_req;
      logic        wr_req;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic [1:0]  sel;      // 0 none, 1 rd, 2 wr
      logic        rd_rv;
      logic        wr_rv;
      logic        idle;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        test_en = 1'b0;
   logic        rd_req = 1'b0, wr_req = 1'b0;
   logic        rd_gnt, wr_gnt, rd_r_valid, wr_r_valid;
   logic [31:0] rd_r_rdata, wr_r_rdata;
   logic        tcdm_req, tcdm_we, tcdm_gnt = 1'b0, tcdm_r_valid = 1'b0;
   logic [31:0] tcdm_add, tcdm_wdata, tcdm_r_rdata = '0;
   logic [3:0]  tcdm_be;
   logic        idle, err;

   int checks = 0;
   int failures = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   axi2mem_tcdm_arbiter #(.OUTSTANDING(4)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .test_en_i      (test_en),
      .rd_req_i       (rd_req),
      .rd_add_i       (RD_ADD),
      .rd_we_i        (1'b1),
      .rd_wdata_i     (RD_WDATA),
      .rd_be_i        (RD_BE),
      .rd_gnt_o       (rd_gnt),
      .rd_r_rdata_o   (rd_r_rdata),
      .rd_r_valid_o   (rd_r_valid),
      .wr_req_i       (wr_req),
      .wr_add_i       (WR_ADD),
      .wr_we_i        (1'b0),
      .wr_wdata_i     (WR_WDATA),
      .wr_be_i        (WR_BE),
      .wr_gnt_o       (wr_gnt),
      .wr_r_rdata_o   (wr_r_rdata),
      .wr_r_valid_o   (wr_r_valid),
      .tcdm_req_o     (tcdm_req),
      .tcdm_add_o     (tcdm_add),
      .tcdm_we_o      (tcdm_we),
      .tcdm_wdata_o   (tcdm_wdata),
      .tcdm_be_o      (tcdm_be),
      .tcdm_gnt_i     (tcdm_gnt),
      .tcdm_r_rdata_i (tcdm_r_rdata),
      .tcdm_r_valid_i (tcdm_r_valid),
      .idle_o         (idle),
      .err_o          (err)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
      end
   endtask

   function automatic void add(input int rd, input int wr, input int g, input int rv,
                               input logic [31:0] rdata, input int sel, input int rrv,
                               input int wrv, input int idl, input int er);
      vec_t v;
      v.rd_req = rd[0];
      v.wr_req = wr[0];
      v.gnt    = g[0];
      v.rv     = rv[0];
      v.rdata  = rdata;
      v.sel    = sel[1:0];
      v.rd_rv  = rrv[0];
      v.wr_rv  = wrv[0];
      v.idle   = idl[0];
      v.err    = er[0];
      vecs.push_back(v);
   endfunction

   initial begin
      logic [31:0] e_add, e_wdata;
      logic [3:0]  e_be;
      logic        e_we;
      vec_t        v;

      //  rd wr g rv rdata         sel rdrv wrrv idle err
      // contention: alternating grants, responses one cycle later
      add(1, 1, 1, 0, 32'h0,         1, 0, 0, 0, 0);
      add(1, 1, 1, 1, 32'hDEAD_BEEF, 2, 1, 0, 0, 0);
      add(1, 1, 1, 1, 32'h1234_5678, 1, 0, 1, 0, 0);
      add(1, 1, 1, 1, 32'hCAFE_0003, 2, 1, 0, 0, 0);
      add(0, 0, 0, 1, 32'h0BAD_0004, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0);
      // lock on wr while rd (rr favours rd) waits
      add(0, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0);
      add(1, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0);
      add(1, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0);
      add(1, 1, 0, 0, 32'h0,         2, 0, 0, 0, 0);
      add(1, 1, 1, 0, 32'h0,         2, 0, 0, 0, 0);
      add(1, 1, 1, 1, 32'h5555_0005, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 32'h6666_0006, 0, 1, 0, 0, 0);
      // withdrawal of a locked rd request
      add(1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0);
      add(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 32'h0,         2, 0, 0, 0, 0);
      add(0, 0, 0, 1, 32'h7777_0007, 0, 0, 1, 0, 0);
      // spurious response on an empty queue
      add(0, 0, 0, 1, 32'h8888_0008, 0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1);
      // fill the queue with no responses
      for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 32'h0, 1, 0, 0, 0, 1);
      add(1, 0, 1, 0, 32'h0,         0, 0, 0, 0, 1);
      add(1, 0, 1, 1, 32'h9999_0009, 0, 1, 0, 0, 1);
      add(1, 0, 1, 0, 32'h0,         1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 32'hA0 + i, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1);

      // reset held with both channels requesting
      rd_req = 1'b1; wr_req = 1'b1; tcdm_gnt = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_tcdm_req", -1, 32'(tcdm_req), 32'h0);
      check("rst_rd_gnt",   -1, 32'(rd_gnt),   32'h0);
      check("rst_wr_gnt",   -1, 32'(wr_gnt),   32'h0);
      check("rst_idle",     -1, 32'(idle),     32'h1);
      check("rst_err",      -1, 32'(err),      32'h0);
      rd_req = 1'b0; wr_req = 1'b0; tcdm_gnt = 1'b0;
      rst_n = 1'b1;
      $display("reset released");

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         rd_req = v.rd_req; wr_req = v.wr_req; tcdm_gnt = v.gnt;
         tcdm_r_valid = v.rv; tcdm_r_rdata = v.rdata;
         #1;
         e_add = '0; e_we = 1'b0; e_wdata = '0; e_be = '0;
         if (v.sel == 2'd1) begin
            e_add = RD_ADD; e_we = 1'b1; e_wdata = RD_WDATA; e_be = RD_BE;
         end else if (v.sel == 2'd2) begin
            e_add = WR_ADD; e_we = 1'b0; e_wdata = WR_WDATA; e_be = WR_BE;
         end
         check("tcdm_req",   i, 32'(tcdm_req),   32'(v.sel != 2'd0));
         check("tcdm_add",   i, tcdm_add,        e_add);
         check("tcdm_we",    i, 32'(tcdm_we),    32'(e_we));
         check("tcdm_wdata", i, tcdm_wdata,      e_wdata);
         check("tcdm_be",    i, 32'(tcdm_be),    32'(e_be));
         check("rd_gnt",     i, 32'(rd_gnt),     32'(v.gnt & (v.sel == 2'd1)));
         check("wr_gnt",     i, 32'(wr_gnt),     32'(v.gnt & (v.sel == 2'd2)));
         check("rd_r_valid", i, 32'(rd_r_valid), 32'(v.rd_rv));
         check("wr_r_valid", i, 32'(wr_r_valid), 32'(v.wr_rv));
         check("rd_r_rdata", i, rd_r_rdata,      v.rdata);
         check("wr_r_rdata", i, wr_r_rdata,      v.rdata);
         check("idle",       i, 32'(idle),       32'(v.idle));
         check("err",        i, 32'(err),        32'(v.err));
         $display("step %0d rd=%0b wr=%0b gnt=%0b rv=%0b sel=%0d add=%h rd_rv=%0b wr_rv=%0b idle=%0b err=%0b",
                  i, v.rd_req, v.wr_req, v.gnt, v.rv, v.sel, tcdm_add, rd_r_valid, wr_r_valid, idle, err);
      end

      // reset with one response outstanding: queue and err are cleared,
      // the late response then raises err without reaching any channel
      @(negedge clk);
      rd_req = 1'b1; tcdm_gnt = 1'b1; tcdm_r_valid = 1'b0;
      #1;
      check("pre_rst_gnt", 100, 32'(rd_gnt), 32'h1);
      @(negedge clk);
      rd_req = 1'b0; tcdm_gnt = 1'b0; rst_n = 1'b0;
      #1;
      check("mid_rst_err",  101, 32'(err),      32'h0);
      check("mid_rst_idle", 101, 32'(idle),     32'h1);
      check("mid_rst_req",  101, 32'(tcdm_req), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; tcdm_r_valid = 1'b1;
      #1;
      check("late_rd_rv",   102, 32'(rd_r_valid), 32'h0);
      check("late_wr_rv",   102, 32'(wr_r_valid), 32'h0);
      check("late_idle",    102, 32'(idle),       32'h1);
      @(negedge clk);
      tcdm_r_valid = 1'b0;
      #1;
      check("late_err",     103, 32'(err),        32'h1);
      $display("mid-operation reset sequence done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
